// File: rtl/bcd_display_ctrl.sv
// Sequential 8-bit binary-to-BCD converter (double-dabble, one step per clock)
// with a 3-digit common-anode 7-segment scanner for the Basys-3 display.
module bcd_display_ctrl #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bin_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [1:0] hundreds,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  state_t      state_reg;
  logic [7:0]  bin_reg;
  logic [7:0]  bin_next;
  logic [9:0]  scratch_reg;
  logic [9:0]  scratch_adj;
  logic [9:0]  scratch_next;
  logic [2:0]  step_reg;

  logic [CW-1:0] refresh_cnt_reg;
  logic [1:0]    digit_idx_reg;
  logic [1:0]    digit_idx_next;
  logic [1:0]    show_idx;
  logic          started_reg;
  logic          wrap;
  logic          blank_hundreds;
  logic          blank_tens;
  logic          show_blank;
  logic [3:0]    show_digit;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1111000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0010000;
      default: seg_encode = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction on the two full BCD nibbles; the 2-bit hundreds field never reaches 5.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_adj
      assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                                      scratch_reg[gi*4 +: 4] + 4'd3 :
                                      scratch_reg[gi*4 +: 4];
    end
  endgenerate
  assign scratch_adj[9:8] = scratch_reg[9:8];

  assign {scratch_next, bin_next} = {scratch_adj, bin_reg} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bin_reg     <= '0;
      scratch_reg <= '0;
      step_reg    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ones        <= '0;
      tens        <= '0;
      hundreds    <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            bin_reg     <= bin_in;
            scratch_reg <= '0;
            step_reg    <= '0;
            busy        <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_reg <= scratch_next;
          bin_reg     <= bin_next;
          step_reg    <= step_reg + 3'd1;
          if (step_reg == 3'd7) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            ones      <= scratch_next[3:0];
            tens      <= scratch_next[7:4];
            hundreds  <= scratch_next[9:8];
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Slot contents are looked up for the digit that will be active after this edge.
  always_comb begin
    wrap           = (refresh_cnt_reg == CNT_MAX);
    digit_idx_next = (digit_idx_reg == 2'd2) ? 2'd0 : digit_idx_reg + 2'd1;
    show_idx       = wrap ? digit_idx_next : digit_idx_reg;
    blank_hundreds = BLANK_LEADING && (hundreds == 2'd0);
    blank_tens     = blank_hundreds && (tens == 4'd0);
    an_next        = 4'b1111;
    show_digit     = ones;
    show_blank     = 1'b0;
    case (show_idx)
      2'd0: an_next = 4'b1110;
      2'd1: begin
        show_digit = tens;
        show_blank = blank_tens;
        an_next    = blank_tens ? 4'b1111 : 4'b1101;
      end
      2'd2: begin
        show_digit = {2'b00, hundreds};
        show_blank = blank_hundreds;
        an_next    = blank_hundreds ? 4'b1111 : 4'b1011;
      end
      default: show_blank = 1'b1;
    endcase
    seg_next = show_blank ? 7'b1111111 : seg_encode(show_digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt_reg <= '0;
      digit_idx_reg   <= '0;
      started_reg     <= 1'b0;
      an              <= 4'b1111;
      seg             <= 7'b1111111;
    end else begin
      started_reg <= 1'b1;
      if (wrap) begin
        refresh_cnt_reg <= '0;
        digit_idx_reg   <= digit_idx_next;
      end else begin
        refresh_cnt_reg <= refresh_cnt_reg + CW'(1);
      end
      if (wrap || !started_reg) begin
        an  <= an_next;
        seg <= seg_next;
      end
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: conversion latency, held results,
// ignored loads, mid-conversion reset, leading-zero blanking and scan timing.
module tb_bcd_display_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bin_in = 8'd0;
  logic       load = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [1:0] hundreds;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int vec_cnt = 0;
  int err_cnt = 0;

  bcd_display_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load),
    .busy(busy), .done(done), .ones(ones), .tens(tens), .hundreds(hundreds),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc7(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after the load edge.
  task automatic pulse_load(input logic [7:0] v);
    bin_in = v;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if ({busy, done} !== 2'b00) begin err_cnt++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
    vec_cnt++; if ({hundreds, tens, ones} !== 10'd0) begin err_cnt++; $display("FAIL reset_digits: got %h expected 000", {hundreds, tens, ones}); end
    vec_cnt++; if (an !== 4'b1111) begin err_cnt++; $display("FAIL reset_an: got %b expected 1111", an); end
    vec_cnt++; if (seg !== 7'b1111111) begin err_cnt++; $display("FAIL reset_seg: got %b expected 1111111", seg); end
    vec_cnt++; if (dp !== 1'b1) begin err_cnt++; $display("FAIL reset_dp: got %b expected 1", dp); end
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++; if (an !== 4'b1110) begin err_cnt++; $display("FAIL first_edge_an: got %b expected 1110", an); end
    vec_cnt++; if (seg !== 7'b1000000) begin err_cnt++; $display("FAIL first_edge_seg: got %b expected 1000000", seg); end
    $display("reset: an=%b seg=%b after first edge", an, seg);
  endtask

  task automatic test_max_value;
    pulse_load(8'd255);
    for (int i = 0; i < 8; i++) begin
      vec_cnt++;
      if ({busy, done} !== 2'b10) begin
        err_cnt++; $display("FAIL max_busy_k%0d: got busy,done=%b expected 10", i, {busy, done});
      end
      @(negedge clk);
    end
    vec_cnt++; if ({busy, done} !== 2'b01) begin err_cnt++; $display("FAIL max_done_edge: got busy,done=%b expected 01", {busy, done}); end
    vec_cnt++; if ({hundreds, tens, ones} !== {2'd2, 4'd5, 4'd5}) begin
      err_cnt++; $display("FAIL max_digits: got %0d,%0d,%0d expected 2,5,5", hundreds, tens, ones);
    end
    $display("conv 255 -> %0d%0d%0d", hundreds, tens, ones);
    @(negedge clk);
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL max_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_blanking;
    int vals[5] = '{0, 100, 9, 42, 255};
    int eh[5]   = '{0, 1, 0, 0, 2};
    int et[5]   = '{0, 0, 0, 4, 5};
    int eo[5]   = '{0, 0, 9, 2, 5};
    for (int k = 0; k < 5; k++) begin
      int lat;
      int n0, n1, n2, nbad;
      logic [10:0] p0, p1, p2, cur;
      pulse_load(8'(vals[k]));
      wait_done(lat);
      vec_cnt++;
      if ({hundreds, tens, ones} !== {2'(eh[k]), 4'(et[k]), 4'(eo[k])}) begin
        err_cnt++; $display("FAIL blank_digits_%0d: got %0d,%0d,%0d expected %0d,%0d,%0d",
                            vals[k], hundreds, tens, ones, eh[k], et[k], eo[k]);
      end
      repeat (15) @(negedge clk);
      p0 = {4'b1110, enc7(eo[k])};
      p1 = (eh[k] == 0 && et[k] == 0) ? {4'b1111, 7'b1111111} : {4'b1101, enc7(et[k])};
      p2 = (eh[k] == 0) ? {4'b1111, 7'b1111111} : {4'b1011, enc7(eh[k])};
      n0 = 0; n1 = 0; n2 = 0; nbad = 0;
      for (int c = 0; c < 12; c++) begin
        cur = {an, seg};
        if (cur === p0) n0++;
        if (cur === p1) n1++;
        if (cur === p2) n2++;
        if (cur !== p0 && cur !== p1 && cur !== p2) nbad++;
        @(negedge clk);
      end
      vec_cnt++; if (n0 !== 4) begin err_cnt++; $display("FAIL scan_ones_%0d: got %0d cycles expected 4", vals[k], n0); end
      vec_cnt++; if (n1 !== ((p1 == p2) ? 8 : 4)) begin err_cnt++; $display("FAIL scan_tens_%0d: got %0d cycles expected %0d", vals[k], n1, (p1 == p2) ? 8 : 4); end
      vec_cnt++; if (n2 !== ((p1 == p2) ? 8 : 4)) begin err_cnt++; $display("FAIL scan_hund_%0d: got %0d cycles expected %0d", vals[k], n2, (p1 == p2) ? 8 : 4); end
      vec_cnt++; if (nbad !== 0) begin err_cnt++; $display("FAIL scan_bad_%0d: got %0d bad cycles expected 0", vals[k], nbad); end
      $display("scan %0d: ones=%0d tens=%0d hund=%0d bad=%0d", vals[k], n0, n1, n2, nbad);
    end
  endtask

  task automatic test_ignored_load;
    int ndone, lat;
    logic [9:0] got;
    pulse_load(8'd42);
    repeat (2) @(negedge clk);
    bin_in = 8'd200;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    bin_in = 8'd77;
    ndone = 0; got = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ndone++; got = {hundreds, tens, ones}; end
    end
    vec_cnt++; if (ndone !== 1) begin err_cnt++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    vec_cnt++; if (got !== {2'd0, 4'd4, 4'd2}) begin err_cnt++; $display("FAIL ignore_result: got %h expected 042", got); end
    $display("conv 42 with ignored load -> %h dones=%0d", got, ndone);
    pulse_load(8'd7);
    wait_done(lat);
    bin_in = 8'd55;
    load   = 1'b1;
    @(negedge clk);
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL load_in_done: got busy=%b expected 0", busy); end
    bin_in = 8'd200;
    @(negedge clk);
    load = 1'b0;
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL load_after_done: got busy=%b expected 1", busy); end
    wait_done(lat);
    vec_cnt++; if (lat !== 8) begin err_cnt++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
    vec_cnt++; if ({hundreds, tens, ones} !== {2'd2, 4'd0, 4'd0}) begin
      err_cnt++; $display("FAIL b2b_result: got %0d,%0d,%0d expected 2,0,0", hundreds, tens, ones);
    end
    $display("conv 200 after done -> %0d%0d%0d lat=%0d", hundreds, tens, ones, lat);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int nspur, lat;
    pulse_load(8'd123);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec_cnt++; if ({busy, done} !== 2'b00) begin err_cnt++; $display("FAIL midrst_busy_done: got %b expected 00", {busy, done}); end
    vec_cnt++; if ({hundreds, tens, ones} !== 10'd0) begin err_cnt++; $display("FAIL midrst_digits: got %h expected 000", {hundreds, tens, ones}); end
    vec_cnt++; if ({an, seg} !== 11'h7FF) begin err_cnt++; $display("FAIL midrst_display: got an=%b seg=%b expected 1111/1111111", an, seg); end
    nspur = 0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) nspur++; end
    rst_n = 1'b1;
    repeat (10) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) nspur++; end
    vec_cnt++; if (nspur !== 0) begin err_cnt++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", nspur); end
    pulse_load(8'd123);
    wait_done(lat);
    vec_cnt++; if (lat !== 8) begin err_cnt++; $display("FAIL midrst_relatency: got %0d expected 8", lat); end
    vec_cnt++; if ({hundreds, tens, ones} !== {2'd1, 4'd2, 4'd3}) begin
      err_cnt++; $display("FAIL midrst_reload: got %0d,%0d,%0d expected 1,2,3", hundreds, tens, ones);
    end
    $display("reset mid-conversion, reload 123 -> %0d%0d%0d", hundreds, tens, ones);
    @(negedge clk);
  endtask

  task automatic test_scan_timing;
    logic [3:0] seq[3] = '{4'b1110, 4'b1101, 4'b1011};
    logic [3:0] prev;
    int lat, start, found;
    pulse_load(8'd255);
    wait_done(lat);
    repeat (15) @(negedge clk);
    prev = an; found = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (an !== prev) begin found = 1; break; end
    end
    vec_cnt++; if (found !== 1) begin err_cnt++; $display("FAIL scan_change: got no an change expected one within 8 cycles"); end
    start = -1;
    for (int s = 0; s < 3; s++) if (an === seq[s]) start = s;
    vec_cnt++; if (start < 0) begin err_cnt++; $display("FAIL scan_slot: got an=%b expected 1110/1101/1011", an); start = 0; end
    for (int i = 0; i < 24; i++) begin
      vec_cnt++;
      if (an !== seq[(start + i / 4) % 3]) begin
        err_cnt++; $display("FAIL scan_seq_%0d: got %b expected %b", i, an, seq[(start + i / 4) % 3]);
      end
      @(negedge clk);
    end
    $display("scan timing: 24 cycles checked from slot %0d", start);
  endtask

  task automatic test_all_values;
    int lat;
    for (int v = 0; v < 256; v++) begin
      pulse_load(8'(v));
      wait_done(lat);
      vec_cnt++;
      if (lat !== 8 || ones !== 4'(v % 10) || tens !== 4'((v / 10) % 10) || hundreds !== 2'(v / 100)) begin
        err_cnt++; $display("FAIL conv_%0d: got %0d,%0d,%0d lat=%0d expected %0d,%0d,%0d lat=8",
                            v, hundreds, tens, ones, lat, v / 100, (v / 10) % 10, v % 10);
      end
      $display("conv %0d -> %0d%0d%0d lat=%0d", v, hundreds, tens, ones, lat);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_max_value();
    test_blanking();
    test_ignored_load();
    test_reset_mid();
    test_scan_timing();
    test_all_values();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
